// File: rtl/lelo_freq_counter.sv
// ---------------------------------------------------------------------------
// lelo_freq_counter
//   Windowed rising-edge counter for the leakage-oscillator temperature
//   sensor. It counts rising edges of the asynchronous oscillator output over
//   a fixed window of WINDOW clk cycles. The count saturates at 2^WIDTH-1.
//   The result is handed out on a valid/ready interface. The block supports
//   single-shot (start) and back-to-back (continuous) measurement.
//
// Ports
//   clk         in   system clock
//   reset_n     in   asynchronous active-low reset
//   osc_in      in   oscillator output, asynchronous to clk
//   start       in   single-cycle request for one measurement (IDLE only)
//   continuous  in   1 = run windows back to back without start
//   result      out  [WIDTH-1:0] captured edge count of the last window
//   ovf         out  result saturated (edges > 2^WIDTH-1)
//   valid       out  result/ovf available
//   ready       in   consumer accepts result when valid & ready
//   busy        out  measurement in progress or waiting to deliver
// ---------------------------------------------------------------------------
module lelo_freq_counter #(
  parameter int WIDTH       = 11,
  parameter int WINDOW      = 1024,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             osc_in,
  input  logic             start,
  input  logic             continuous,
  output logic [WIDTH-1:0] result,
  output logic             ovf,
  output logic             valid,
  input  logic             ready,
  output logic             busy
);

  localparam int TW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [WIDTH-1:0] COUNT_MAX = '1;
  localparam logic [TW-1:0]    TIMER_LOAD = TW'(WINDOW - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t               state;
  logic [SYNC_STAGES-1:0] sync;
  logic                 prev;
  logic [WIDTH-1:0]     count;
  logic                 ovf_int;
  logic [TW-1:0]        timer;

  // Synchroniser chain followed by one edge-detect flop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], osc_in};
      prev <= sync[SYNC_STAGES-1];
    end
  end

  logic             osc_edge;
  logic             at_max;
  logic [WIDTH-1:0] count_upd;
  logic             ovf_upd;
  logic             slot_free;

  // The count value and overflow flag, updated for this cycle's edge.
  // The count sticks at all-ones, and the overflow flag records that an edge was lost.
  assign osc_edge  = sync[SYNC_STAGES-1] & ~prev;
  assign at_max    = (count == COUNT_MAX);
  assign count_upd = (osc_edge && !at_max) ? count + WIDTH'(1) : count;
  assign ovf_upd   = ovf_int | (osc_edge & at_max);
  assign slot_free = !valid || ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      count   <= '0;
      ovf_int <= 1'b0;
      timer   <= '0;
      result  <= '0;
      ovf     <= 1'b0;
      valid   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      // A consumed result drops valid. A capture later in this block overrides that.
      if (valid && ready) begin
        valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (start || continuous) begin
            state   <= MEASURE;
            busy    <= 1'b1;
            count   <= '0;
            ovf_int <= 1'b0;
            timer   <= TIMER_LOAD;
          end
        end

        MEASURE: begin
          if (timer == '0) begin
            // Last window cycle: an edge here still counts.
            if (slot_free) begin
              result <= count_upd;
              ovf    <= ovf_upd;
              valid  <= 1'b1;
              if (continuous) begin
                state   <= MEASURE;
                count   <= '0;
                ovf_int <= 1'b0;
                timer   <= TIMER_LOAD;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
              end
            end else begin
              count   <= count_upd;
              ovf_int <= ovf_upd;
              state   <= HOLD;
            end
          end else begin
            timer   <= timer - TW'(1);
            count   <= count_upd;
            ovf_int <= ovf_upd;
          end
        end

        HOLD: begin
          // Edges are ignored here. The frozen count waits for the slot.
          if (valid && ready) begin
            result <= count;
            ovf    <= ovf_int;
            valid  <= 1'b1;
            if (continuous) begin
              state   <= MEASURE;
              count   <= '0;
              ovf_int <= 1'b0;
              timer   <= TIMER_LOAD;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
